// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Merges NUM_CH writeback requestors onto one registered dmem/RF
//            write port with a round-robin or fixed-priority grant.
// Revision : 1.0  initial parametrised release
// ============================================================================
module wb_port_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter bit RR_MODE = 1'b1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH-1:0]        in_dmem_wr,
  input  logic [NUM_CH*ADDR_W-1:0] in_dmem_addr,
  input  logic [NUM_CH*DATA_W-1:0] in_dmem_data,
  input  logic [NUM_CH-1:0]        in_RF_wr,
  input  logic [NUM_CH*ADDR_W-1:0] in_RF_addr,
  input  logic [NUM_CH*DATA_W-1:0] in_RF_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     dmem_wr,
  output logic [ADDR_W-1:0]        dmem_addr,
  output logic [DATA_W-1:0]        dmem_data,
  output logic                     RF_wr,
  output logic [ADDR_W-1:0]        RF_addr,
  output logic [DATA_W-1:0]        RF_data,
  output logic [CH_W-1:0]          out_ch
);

  localparam logic [CH_W:0]   c_num_ch  = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] c_last_ch = CH_W'(NUM_CH - 1);

  logic              w_load;
  logic              w_found;
  logic              w_xfer;
  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_sel;
  logic [CH_W:0]     w_idx;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic              w_dmem_wr;
  logic [ADDR_W-1:0] w_dmem_addr;
  logic [DATA_W-1:0] w_dmem_data;
  logic              w_rf_wr;
  logic [ADDR_W-1:0] w_rf_addr;
  logic [DATA_W-1:0] w_rf_data;

  logic              r_out_valid;
  logic              r_dmem_wr;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_data;
  logic              r_rf_wr;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_ptr;

  assign w_load = !r_out_valid || out_ready;

  // Grant search: RR walks upward from the pointer with wrap; fixed keeps the last (highest) hit.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    w_grant = '0;
    if (RR_MODE) begin
      for (int k = 0; k < NUM_CH; k++) begin
        w_idx = {1'b0, r_ptr} + (CH_W+1)'(k);
        if (w_idx >= c_num_ch) w_idx = w_idx - c_num_ch;
        if (!w_found && in_valid[w_idx[CH_W-1:0]]) begin
          w_found = 1'b1;
          w_sel   = w_idx[CH_W-1:0];
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (in_valid[k]) begin
          w_found = 1'b1;
          w_sel   = CH_W'(k);
        end
      end
    end
    if (w_found) w_grant[w_sel] = 1'b1;
  end

  // Reset gating keeps in_ready low while held in reset, where load would otherwise be high.
  assign in_ready  = (w_load && rst_n) ? w_grant : '0;
  assign w_xfer    = w_found && w_load;
  assign w_ptr_nxt = (w_sel == c_last_ch) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_dmem_wr   = 1'b0;
    w_dmem_addr = '0;
    w_dmem_data = '0;
    w_rf_wr     = 1'b0;
    w_rf_addr   = '0;
    w_rf_data   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_dmem_wr   = in_dmem_wr[i];
        w_dmem_addr = in_dmem_addr[i*ADDR_W +: ADDR_W];
        w_dmem_data = in_dmem_data[i*DATA_W +: DATA_W];
        w_rf_wr     = in_RF_wr[i];
        w_rf_addr   = in_RF_addr[i*ADDR_W +: ADDR_W];
        w_rf_data   = in_RF_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dmem_wr   <= 1'b0;
      r_dmem_addr <= '0;
      r_dmem_data <= '0;
      r_rf_wr     <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_data   <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_dmem_wr   <= w_dmem_wr;
      r_dmem_addr <= w_dmem_addr;
      r_dmem_data <= w_dmem_data;
      r_rf_wr     <= w_rf_wr;
      r_rf_addr   <= w_rf_addr;
      r_rf_data   <= w_rf_data;
      r_out_ch    <= w_sel;
      if (RR_MODE) r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign dmem_wr   = r_dmem_wr;
  assign dmem_addr = r_dmem_addr;
  assign dmem_data = r_dmem_data;
  assign RF_wr     = r_rf_wr;
  assign RF_addr   = r_rf_addr;
  assign RF_data   = r_rf_data;
  assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Two arbiter instances (2-ch fixed priority, 4-ch round-robin)
//            run in lockstep against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

  typedef struct {
    int          ptr;
    logic        ov;
    logic        dwr;
    logic [15:0] daddr;
    logic [31:0] ddata;
    logic        rwr;
    logic [15:0] raddr;
    logic [31:0] rdata;
    int          ch;
  } mstate_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Stimulus storage, index 0 = fixed-priority DUT, index 1 = round-robin DUT
  logic [3:0]  s_valid [2];
  logic [3:0]  s_dwr   [2];
  logic [3:0]  s_rwr   [2];
  logic [15:0] s_daddr [2][4];
  logic [15:0] s_raddr [2][4];
  logic [31:0] s_ddata [2][4];
  logic [31:0] s_rdata [2][4];
  logic        s_ordy  [2];
  mstate_t     m [2];

  logic [1:0]   fp_in_ready;
  logic         fp_out_valid, fp_dmem_wr, fp_rf_wr;
  logic [15:0]  fp_dmem_addr, fp_rf_addr;
  logic [31:0]  fp_dmem_data, fp_rf_data;
  logic [0:0]   fp_out_ch;
  logic [3:0]   rr_in_ready;
  logic         rr_out_valid, rr_dmem_wr, rr_rf_wr;
  logic [15:0]  rr_dmem_addr, rr_rf_addr;
  logic [31:0]  rr_dmem_data, rr_rf_data;
  logic [1:0]   rr_out_ch;

  wb_port_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(32), .RR_MODE(1'b0)) u_fp (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (s_valid[0][1:0]),
    .in_ready     (fp_in_ready),
    .in_dmem_wr   (s_dwr[0][1:0]),
    .in_dmem_addr ({s_daddr[0][1], s_daddr[0][0]}),
    .in_dmem_data ({s_ddata[0][1], s_ddata[0][0]}),
    .in_RF_wr     (s_rwr[0][1:0]),
    .in_RF_addr   ({s_raddr[0][1], s_raddr[0][0]}),
    .in_RF_data   ({s_rdata[0][1], s_rdata[0][0]}),
    .out_valid    (fp_out_valid),
    .out_ready    (s_ordy[0]),
    .dmem_wr      (fp_dmem_wr),
    .dmem_addr    (fp_dmem_addr),
    .dmem_data    (fp_dmem_data),
    .RF_wr        (fp_rf_wr),
    .RF_addr      (fp_rf_addr),
    .RF_data      (fp_rf_data),
    .out_ch       (fp_out_ch)
  );

  wb_port_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(32), .RR_MODE(1'b1)) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (s_valid[1]),
    .in_ready     (rr_in_ready),
    .in_dmem_wr   (s_dwr[1]),
    .in_dmem_addr ({s_daddr[1][3], s_daddr[1][2], s_daddr[1][1], s_daddr[1][0]}),
    .in_dmem_data ({s_ddata[1][3], s_ddata[1][2], s_ddata[1][1], s_ddata[1][0]}),
    .in_RF_wr     (s_rwr[1]),
    .in_RF_addr   ({s_raddr[1][3], s_raddr[1][2], s_raddr[1][1], s_raddr[1][0]}),
    .in_RF_data   ({s_rdata[1][3], s_rdata[1][2], s_rdata[1][1], s_rdata[1][0]}),
    .out_valid    (rr_out_valid),
    .out_ready    (s_ordy[1]),
    .dmem_wr      (rr_dmem_wr),
    .dmem_addr    (rr_dmem_addr),
    .dmem_data    (rr_dmem_data),
    .RF_wr        (rr_rf_wr),
    .RF_addr      (rr_rf_addr),
    .RF_data      (rr_rf_data),
    .out_ch       (rr_out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rules; -1 when nobody requests
  function automatic int pick(input int n, input bit rr, input int ptr, input logic [3:0] v);
    if (rr) begin
      for (int k = 0; k < n; k++)
        if (v[(ptr + k) % n]) return (ptr + k) % n;
    end else begin
      for (int c = n - 1; c >= 0; c--)
        if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic mstate_t mreset();
    mstate_t z;
    z.ptr = 0; z.ov = 1'b0; z.dwr = 1'b0; z.daddr = '0; z.ddata = '0;
    z.rwr = 1'b0; z.raddr = '0; z.rdata = '0; z.ch = 0;
    return z;
  endfunction

  task automatic check_outs(input string tag, input int d);
    if (d == 0) begin
      chk({tag, ".fp.out_valid"}, 64'(fp_out_valid), 64'(m[0].ov));
      chk({tag, ".fp.dmem_wr"},   64'(fp_dmem_wr),   64'(m[0].dwr));
      chk({tag, ".fp.dmem_addr"}, 64'(fp_dmem_addr), 64'(m[0].daddr));
      chk({tag, ".fp.dmem_data"}, 64'(fp_dmem_data), 64'(m[0].ddata));
      chk({tag, ".fp.RF_wr"},     64'(fp_rf_wr),     64'(m[0].rwr));
      chk({tag, ".fp.RF_addr"},   64'(fp_rf_addr),   64'(m[0].raddr));
      chk({tag, ".fp.RF_data"},   64'(fp_rf_data),   64'(m[0].rdata));
      chk({tag, ".fp.out_ch"},    64'(fp_out_ch),    64'(m[0].ch));
    end else begin
      chk({tag, ".rr.out_valid"}, 64'(rr_out_valid), 64'(m[1].ov));
      chk({tag, ".rr.dmem_wr"},   64'(rr_dmem_wr),   64'(m[1].dwr));
      chk({tag, ".rr.dmem_addr"}, 64'(rr_dmem_addr), 64'(m[1].daddr));
      chk({tag, ".rr.dmem_data"}, 64'(rr_dmem_data), 64'(m[1].ddata));
      chk({tag, ".rr.RF_wr"},     64'(rr_rf_wr),     64'(m[1].rwr));
      chk({tag, ".rr.RF_addr"},   64'(rr_rf_addr),   64'(m[1].raddr));
      chk({tag, ".rr.RF_data"},   64'(rr_rf_data),   64'(m[1].rdata));
      chk({tag, ".rr.out_ch"},    64'(rr_out_ch),    64'(m[1].ch));
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it
  task automatic cycle(input string tag);
    int   g [2];
    bit   xfer [2];
    logic [3:0] exp_rdy;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d]    = pick(d ? 4 : 2, d == 1, m[d].ptr, s_valid[d]);
      xfer[d] = (g[d] >= 0) && (!m[d].ov || s_ordy[d]) && rst_n;
      exp_rdy = xfer[d] ? 4'(1 << g[d]) : 4'b0000;
      if (d == 0) chk({tag, ".fp.in_ready"}, 64'(fp_in_ready), 64'(exp_rdy[1:0]));
      else        chk({tag, ".rr.in_ready"}, 64'(rr_in_ready), 64'(exp_rdy));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) m[d] = mreset();
      else if (xfer[d]) begin
        m[d].ov    = 1'b1;
        m[d].ch    = g[d];
        m[d].dwr   = s_dwr[d][g[d]];
        m[d].daddr = s_daddr[d][g[d]];
        m[d].ddata = s_ddata[d][g[d]];
        m[d].rwr   = s_rwr[d][g[d]];
        m[d].raddr = s_raddr[d][g[d]];
        m[d].rdata = s_rdata[d][g[d]];
        if (d == 1) m[d].ptr = (g[d] + 1) % 4;
      end else if (s_ordy[d]) m[d].ov = 1'b0;
      check_outs(tag, d);
    end
  endtask

  task automatic rand_fields(input int d);
    for (int c = 0; c < 4; c++) begin
      s_dwr[d][c]   = 1'($urandom_range(0, 1));
      s_rwr[d][c]   = 1'($urandom_range(0, 1));
      s_daddr[d][c] = 16'($urandom);
      s_raddr[d][c] = 16'($urandom);
      s_ddata[d][c] = $urandom;
      s_rdata[d][c] = $urandom;
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = '0;
      s_ordy[d]  = 1'b1;
      rand_fields(d);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    m[0] = mreset();
    m[1] = mreset();
    check_outs("in_reset", 0);
    check_outs("in_reset", 1);
    chk("in_reset.rr.in_ready", 64'(rr_in_ready), 64'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    do_reset();
    cycle("idle");

    // Single request on ch0 of both instances
    s_valid[0] = 4'b0001; s_valid[1] = 4'b0001;
    s_dwr[0][0] = 1'b1; s_daddr[0][0] = 16'h0010; s_ddata[0][0] = 32'hDEADBEEF;
    s_dwr[1][0] = 1'b1; s_daddr[1][0] = 16'h0010; s_ddata[1][0] = 32'hDEADBEEF;
    #1;
    chk("single.rr.in_ready_const", 64'(rr_in_ready), 64'h1);
    cycle("single");
    chk("single.rr.dmem_addr_const", 64'(rr_dmem_addr), 64'h0010);
    chk("single.rr.dmem_data_const", 64'(rr_dmem_data), 64'hDEADBEEF);
    chk("single.rr.out_valid_const", 64'(rr_out_valid), 64'h1);

    // Fixed priority: ch1 always wins
    s_valid[1] = '0;
    for (int k = 0; k < 6; k++) begin
      rand_fields(0);
      s_valid[0] = 4'b0011;
      #1;
      chk("fixed.fp.in_ready_const", 64'(fp_in_ready), 64'h2);
      cycle("fixed");
      chk("fixed.fp.out_ch_const", 64'(fp_out_ch), 64'h1);
    end

    // Round-robin fairness from a fresh pointer
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rand_fields(1);
      s_valid[1] = 4'b1111;
      cycle("rr_fair");
      chk("rr_fair.out_ch_seq", 64'(rr_out_ch), 64'(k % 4));
      chk("rr_fair.no_bubble", 64'(rr_out_valid), 64'h1);
    end

    // Backpressure: ch2 beat held while ch0 waits
    s_valid[1] = 4'b0100; rand_fields(1);
    cycle("bp_load");
    s_valid[1] = 4'b0001; s_ordy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle("bp_stall");
      chk("bp_stall.out_ch_const", 64'(rr_out_ch), 64'h2);
    end
    s_ordy[1] = 1'b1;
    cycle("bp_release");
    chk("bp_release.out_ch_const", 64'(rr_out_ch), 64'h0);
    s_valid[1] = 4'b1111; rand_fields(1);
    cycle("bp_ptr");
    chk("bp_ptr.out_ch_const", 64'(rr_out_ch), 64'h1);

    // Wrap and sparse: pointer to 3, then only ch1
    s_valid[1] = 4'b0100; rand_fields(1);
    cycle("wrap_set");
    s_valid[1] = 4'b0010; rand_fields(1);
    cycle("wrap_sparse");
    chk("wrap_sparse.out_ch_const", 64'(rr_out_ch), 64'h1);
    s_valid[1] = 4'b0000;
    cycle("wrap_drain");
    chk("wrap_drain.out_valid_const", 64'(rr_out_valid), 64'h0);
    s_valid[1] = 4'b1111; rand_fields(1);
    cycle("wrap_ptr");
    chk("wrap_ptr.out_ch_const", 64'(rr_out_ch), 64'h2);

    // Randomized traffic on both instances
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        rand_fields(d);
        s_valid[d] = 4'($urandom);
        s_ordy[d]  = ($urandom_range(0, 3) != 0);
      end
      cycle("random");
    end

    // Reset asserted between edges during a stall
    idle_inputs();
    s_valid[1] = 4'b0001; s_rwr[1][0] = 1'b1;
    s_valid[0] = 4'b0001; s_rwr[0][0] = 1'b1;
    cycle("mid_load");
    s_valid[1] = 4'b1000; s_ordy[1] = 1'b0; s_ordy[0] = 1'b0;
    cycle("mid_stall");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset.rr.out_valid", 64'(rr_out_valid), 64'h0);
    chk("mid_reset.rr.RF_wr",     64'(rr_rf_wr),     64'h0);
    chk("mid_reset.fp.out_valid", 64'(fp_out_valid), 64'h0);
    m[0] = mreset();
    m[1] = mreset();
    @(posedge clk);
    #1;
    cycle("mid_in_reset");
    rst_n = 1'b1;
    s_valid[1] = 4'b1111; s_ordy[1] = 1'b1; s_ordy[0] = 1'b1; rand_fields(1);
    cycle("mid_after");
    chk("mid_after.out_ch_const", 64'(rr_out_ch), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
